alu_seq: RTL and testbench
==========================

Name: alu_seq

Overview:
- Registered, multi-cycle successor to the combinational 8-bit ALU.
- Width is parametrised. Adds a start/valid handshake, a registered flag word, and carry-in chaining.
- Adds iterative unsigned multiply and divide with a double-width result.
- Sits between the register file and the accumulator/flag register of the processor datapath. The sequencer issues one operation at a time and waits for valid.

Parameters:
- ALU_rozm_data, 8, operand/result width W (must be 4..32)

Ports:
- clk  in  1  system clock, rising-edge
- rst  in  1  synchronous, active-high reset
- start  in  1  launch operation; sampled only when ready=1
- ready  out  1  1 when idle and able to accept start
- alu_op  in  4  operation code, captured with start
- a  in  W  operand A, captured with start
- b  in  W  operand B, captured with start
- C_in  in  1  carry/borrow in, captured with start
- out  out  W  result (low half for MUL, quotient for DIV)
- out_hi  out  W  MUL high half / DIV remainder; 0 for other ops
- valid  out  1  one-cycle pulse: out, out_hi and flags updated this cycle
- P  out  1  parity: 1 when out has an even number of ones
- Z  out  1  zero: out == 0
- S  out  1  sign: out[W-1]
- C  out  1  carry
- OV  out  1  signed overflow / divide error

Behaviour:
- Reset (sync, rst=1 at a clk edge) forces:
  - state IDLE, ready=1, valid=0;
  - out, out_hi, P, Z, S, C, OV all 0.
  - Reset overrides any in-flight operation; the partial result is discarded and no valid is issued.
- Operands, opcode and C_in are latched on start&&ready. Later input changes have no effect until the next start.
- start while ready=0 is ignored; it is not queued.
- Results and flags are registered. They hold their value between valid pulses.
- Opcode map (W-bit arithmetic; carry is bit W of the extended sum):
  - 0 PASS_B: out=b; C=0, OV=0
  - 1 AND, 2 OR, 3 XOR; C=0, OV=0
  - 4 ADD: {C,out}=a+b+C_in; OV=(a[W-1]==b[W-1])&&(out[W-1]!=a[W-1])
  - 5 SUB: out=a-b-C_in; C=borrow (1 when a < b+C_in); OV=(a[W-1]!=b[W-1])&&(out[W-1]!=a[W-1])
  - 6 SHL: {C,out}={a,0}; OV=0
  - 7 NOT: out=~a; C=0, OV=0
  - 8 MUL (unsigned): {out_hi,out}=a*b; C=(out_hi!=0); OV=0
  - 9 DIV (unsigned): out=a/b, out_hi=a%b; C=0
  - 10..15 reserved: out=0, out_hi=0; all flags computed from out=0 (Z=1, P=1); C=0, OV=0
- P, Z and S always derive from out (low half), never from out_hi.
- FSM states:
  - IDLE: ready=1. On start: opcode 8 -> MUL, opcode 9 -> DIV, else -> DONE.
  - MUL: shift-add, one bit of b per cycle, W cycles, then -> DONE.
  - DIV: restoring, one quotient bit per cycle, W cycles, then -> DONE.
  - DIV with b==0 skips iteration and goes straight to DONE with out=all ones, out_hi=a, OV=1.
  - DONE: results/flags written, valid=1 for this cycle only, ready=0, -> IDLE.
- Latency, start cycle to valid cycle:
  - single-cycle ops and DIV by zero: 2 clocks
  - MUL/DIV: W+2 clocks
- Throughput: ready returns 1 in the cycle after valid. Back-to-back simple ops therefore issue every 2 clocks.

Optional Feature:
- Macro: ALU_SEQ_MULDIV_EN.
- Defined: opcodes 8/9 and the MUL/DIV states are built as specified.
- Undefined: MUL/DIV logic is not synthesised and opcodes 8/9 behave exactly as reserved opcodes. Latency for every opcode is then 2 clocks and out_hi is always 0.

Test Plan:
- Reset: rst=1 for 2 clocks, then apply start with ADD a=5 b=5 and hold rst=1 -> no valid pulse; ready=1; out=0.
- ADD, W=8:
  - a=8'h7F b=8'h01 C_in=0 -> out=8'h80, S=1, OV=1, C=0, P=0, Z=0, 2 clocks after start.
  - Then a=8'hFF b=8'h01 C_in=1 -> out=8'h01, C=1, OV=0.
- SUB borrow: a=4 b=5 -> out=8'hFF, C=1, S=1, P=1, OV=0. Then a=5 b=4 -> out=1, C=0.
- MUL: a=8'hFF b=8'hFF -> out=8'h01, out_hi=8'hFE, C=1, valid exactly 10 clocks after start.
  - start pulses issued while busy must be ignored.
- DIV:
  - a=100 b=7 -> out=14, out_hi=2, OV=0, latency 10.
  - a=9 b=0 -> out=8'hFF, out_hi=9, OV=1, latency 2.
- Mid-op reset and reserved opcode:
  - Assert rst during the 4th MUL cycle -> no valid pulse; next clock ready=1 with all outputs 0.
  - Then opcode 12 -> out=0, Z=1, P=1, C=0.

Source files
------------

// File: rtl/alu_seq.sv
// Registered multi-cycle ALU with start/valid handshake, registered flag word and carry-in.
// Define ALU_SEQ_MULDIV_EN to build the iterative unsigned MUL (shift-add) / DIV (restoring) path.
module alu_seq #(
   parameter int ALU_rozm_data = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   output logic                     ready,
   input  logic [3:0]               alu_op,
   input  logic [ALU_rozm_data-1:0] a,
   input  logic [ALU_rozm_data-1:0] b,
   input  logic                     C_in,
   output logic [ALU_rozm_data-1:0] out,
   output logic [ALU_rozm_data-1:0] out_hi,
   output logic                     valid,
   output logic                     P,
   output logic                     Z,
   output logic                     S,
   output logic                     C,
   output logic                     OV
);
   localparam int W  = ALU_rozm_data;
   localparam int CW = $clog2(W);

   typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
   state_t state, state_nxt;

   logic         ld, ld_c, ld_ov;
   logic [W-1:0] ld_lo, ld_hi;

`ifdef ALU_SEQ_MULDIV_EN
   // wa: multiplicand / divisor; hi: partial product high / remainder; lo: multiplier / quotient
   logic [W-1:0]  wa, hi, lo, step_hi, step_lo;
   logic [CW-1:0] cnt;
   logic [W:0]    sum, shifted, trial;

   always_comb begin
      sum     = {1'b0, hi} + (lo[0] ? {1'b0, wa} : '0);
      shifted = {hi, lo[W-1]};
      trial   = shifted - {1'b0, wa};
      if (state == MUL) begin
         step_hi = sum[W:1];
         step_lo = {sum[0], lo[W-1:1]};
      end else begin
         // a negative trial (bit W set) means restore: keep the shifted remainder
         step_hi = trial[W] ? shifted[W-1:0] : trial[W-1:0];
         step_lo = {lo[W-2:0], ~trial[W]};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wa  <= '0;
         hi  <= '0;
         lo  <= '0;
         cnt <= '0;
      end else if (state == IDLE && start) begin
         wa  <= (alu_op == 4'd8) ? a : b;
         lo  <= (alu_op == 4'd8) ? b : a;
         hi  <= '0;
         cnt <= '0;
      end else if (state == MUL || state == DIV) begin
         hi  <= step_hi;
         lo  <= step_lo;
         cnt <= cnt + 1'b1;
      end
   end
`endif

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      ld        = 1'b0;
      ld_lo     = '0;
      ld_hi     = '0;
      ld_c      = 1'b0;
      ld_ov     = 1'b0;
      ready     = (state == IDLE);
      valid     = (state == DONE);
      case (state)
         IDLE: if (start) begin
            ld        = 1'b1;
            state_nxt = DONE;
            case (alu_op)
               4'd0: ld_lo = b;
               4'd1: ld_lo = a & b;
               4'd2: ld_lo = a | b;
               4'd3: ld_lo = a ^ b;
               4'd4: begin
                  {ld_c, ld_lo} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, C_in};
                  ld_ov = (a[W-1] == b[W-1]) && (ld_lo[W-1] != a[W-1]);
               end
               4'd5: begin
                  // bit W of the extended difference is the borrow
                  {ld_c, ld_lo} = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, C_in};
                  ld_ov = (a[W-1] != b[W-1]) && (ld_lo[W-1] != a[W-1]);
               end
               4'd6: {ld_c, ld_lo} = {a, 1'b0};
               4'd7: ld_lo = ~a;
`ifdef ALU_SEQ_MULDIV_EN
               4'd8: begin
                  ld        = 1'b0;
                  state_nxt = MUL;
               end
               4'd9: begin
                  if (b == '0) begin
                     ld_lo = '1;
                     ld_hi = a;
                     ld_ov = 1'b1;
                  end else begin
                     ld        = 1'b0;
                     state_nxt = DIV;
                  end
               end
`endif
               default: ;
            endcase
         end
`ifdef ALU_SEQ_MULDIV_EN
         MUL, DIV: if (cnt == CW'(W-1)) begin
            ld        = 1'b1;
            ld_lo     = step_lo;
            ld_hi     = step_hi;
            ld_c      = (state == MUL) && (step_hi != '0);
            state_nxt = DONE;
         end
`endif
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out    <= '0;
         out_hi <= '0;
         P      <= 1'b0;
         Z      <= 1'b0;
         S      <= 1'b0;
         C      <= 1'b0;
         OV     <= 1'b0;
      end else if (ld) begin
         out    <= ld_lo;
         out_hi <= ld_hi;
         P      <= ~^ld_lo;
         Z      <= (ld_lo == '0);
         S      <= ld_lo[W-1];
         C      <= ld_c;
         OV     <= ld_ov;
      end
   end

endmodule

// File: tb/tb_alu_seq.sv
// Randomized + directed bench for alu_seq against a plain-arithmetic reference model.
module tb_alu_seq;
   localparam int W = 8;
`ifdef ALU_SEQ_MULDIV_EN
   localparam bit MD = 1'b1;
`else
   localparam bit MD = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         rst, start, C_in;
   logic [3:0]   alu_op;
   logic [W-1:0] a, b, out, out_hi;
   logic         ready, valid, P, Z, S, C, OV;

   int n_chk  = 0;
   int n_pass = 0;

   alu_seq #(.ALU_rozm_data(W)) dut (
      .clk(clk), .rst(rst), .start(start), .ready(ready), .alu_op(alu_op),
      .a(a), .b(b), .C_in(C_in), .out(out), .out_hi(out_hi), .valid(valid),
      .P(P), .Z(Z), .S(S), .C(C), .OV(OV)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0] lo;
      logic [W-1:0] hi;
      logic         c;
      logic         ov;
      int           lat;
   } res_t;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   function automatic longint sval(input logic [W-1:0] x);
      return x[W-1] ? longint'(x) - (longint'(1) << W) : longint'(x);
   endfunction

   function automatic logic ovf(input longint t);
      longint lim = longint'(1) << (W - 1);
      return (t > lim - 1) || (t < -lim);
   endfunction

   function automatic res_t model(input logic [3:0] op, input logic [W-1:0] x, y, input logic ci);
      res_t r;
      longint unsigned s;
      longint unsigned m = longint'(1) << W;
      r.lo = '0; r.hi = '0; r.c = 1'b0; r.ov = 1'b0; r.lat = 2;
      case (op)
         4'd0: r.lo = y;
         4'd1: r.lo = x & y;
         4'd2: r.lo = x | y;
         4'd3: r.lo = x ^ y;
         4'd4: begin
            s = 64'(x) + 64'(y) + 64'(ci);
            r.lo = W'(s); r.c = (s >= m);
            r.ov = ovf(sval(x) + sval(y) + longint'(ci));
         end
         4'd5: begin
            r.lo = W'(64'(x) - 64'(y) - 64'(ci));
            r.c  = (64'(x) < 64'(y) + 64'(ci));
            r.ov = ovf(sval(x) - sval(y) - longint'(ci));
         end
         4'd6: begin
            s = 64'(x) * 2;
            r.lo = W'(s); r.c = (s >= m);
         end
         4'd7: r.lo = ~x;
         4'd8: if (MD) begin
            s = 64'(x) * 64'(y);
            r.lo = W'(s); r.hi = W'(s >> W); r.c = (r.hi != 0); r.lat = W + 2;
         end
         4'd9: if (MD) begin
            if (y == 0) begin
               r.lo = '1; r.hi = x; r.ov = 1'b1;
            end else begin
               r.lo = x / y; r.hi = x % y; r.lat = W + 2;
            end
         end
         default: ;
      endcase
      return r;
   endfunction

   task automatic run_op(input logic [3:0] op, input logic [W-1:0] xa, xb, input logic xc);
      res_t e;
      int   lat, guard;
      bit   got;
      e = model(op, xa, xb, xc);
      guard = 0;
      while (!ready && guard < 50) begin
         @(posedge clk); #1; guard++;
      end
      chk("ready_before_start", ready, 1);
      start = 1; alu_op = op; a = xa; b = xb; C_in = xc;
      @(posedge clk); #1;
      start = 0;
      lat = 1; got = 0;
      while (!got && lat < 4 * W) begin
         lat++;
         if (valid) got = 1;
         else begin
            // scramble inputs and fire ignored starts while busy
            start = 1'($urandom_range(0, 1)); alu_op = 4'($urandom);
            a = W'($urandom); b = W'($urandom); C_in = 1'($urandom);
            @(posedge clk); #1;
         end
      end
      start = 0;
      chk($sformatf("op%0d_valid", op), got, 1);
      chk($sformatf("op%0d_latency", op), lat, e.lat);
      chk($sformatf("op%0d_out", op), out, e.lo);
      chk($sformatf("op%0d_out_hi", op), out_hi, e.hi);
      chk($sformatf("op%0d_flags_PZSC_OV", op), {P, Z, S, C, OV},
          {~^e.lo, e.lo == 0, e.lo[W-1], e.c, e.ov});
      @(posedge clk); #1;
      chk($sformatf("op%0d_valid_pulse", op), valid, 0);
      chk($sformatf("op%0d_ready_after", op), ready, 1);
      chk($sformatf("op%0d_out_hold", op), out, e.lo);
   endtask

   initial begin
      int nv;
      rst = 1; start = 0; alu_op = 0; a = 0; b = 0; C_in = 0;
      repeat (2) @(posedge clk);
      #1;
      start = 1; alu_op = 4'd4; a = 5; b = 5;
      nv = 0;
      repeat (2) begin
         @(posedge clk); #1; nv += int'(valid);
      end
      chk("rst_no_valid", nv, 0);
      chk("rst_ready", ready, 1);
      chk("rst_out", out, 0);
      chk("rst_out_hi", out_hi, 0);
      chk("rst_flags", {P, Z, S, C, OV}, 0);
      start = 0; rst = 0;

      run_op(4'd4, 8'h7F, 8'h01, 1'b0);
      run_op(4'd4, 8'hFF, 8'h01, 1'b1);
      run_op(4'd5, 8'd4, 8'd5, 1'b0);
      run_op(4'd5, 8'd5, 8'd4, 1'b0);
      run_op(4'd8, 8'hFF, 8'hFF, 1'b0);
      run_op(4'd9, 8'd100, 8'd7, 1'b0);
      run_op(4'd9, 8'd9, 8'd0, 1'b0);

`ifdef ALU_SEQ_MULDIV_EN
      start = 1; alu_op = 4'd8; a = 8'hC3; b = 8'h5A;
      @(posedge clk); #1;
      start = 0; nv = 0;
      repeat (3) begin
         nv += int'(valid); @(posedge clk); #1;
      end
      nv += int'(valid);
      rst = 1;
      @(posedge clk); #1;
      rst = 0;
      nv += int'(valid);
      repeat (W) begin
         @(posedge clk); #1; nv += int'(valid);
      end
      chk("midrst_no_valid", nv, 0);
`else
      rst = 1;
      @(posedge clk); #1;
      rst = 0;
`endif
      chk("midrst_ready", ready, 1);
      chk("midrst_out", out, 0);
      chk("midrst_out_hi", out_hi, 0);
      chk("midrst_flags", {P, Z, S, C, OV}, 0);

      run_op(4'd12, 8'hA5, 8'h3C, 1'b1);

      for (int i = 0; i < 40; i++) begin
         logic [W-1:0] ra, rb;
         ra = W'($urandom);
         rb = (i % 7 == 0) ? '0 : W'($urandom);
         run_op(4'($urandom), ra, rb, 1'($urandom));
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
